// File: rtl/spi_reg_responder.sv
// ============================================================================
// Module   : spi_reg_responder
// Brief    : Oversampled SPI mode-0 responder bridging one command+data frame
//            onto a single-cycle synchronous register bus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_reg_responder #(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SPI_CSN,
    input  logic              SPI_CLK,
    input  logic              SPI_MOSI,
    output logic              SPI_MISO,
    output logic [ADDR_W-1:0] reg_addr,
    output logic              reg_wr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              reg_rd,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic              frame_err
);

    localparam int c_CMD_W   = 1 + ADDR_W;
    localparam int c_FRAME_W = c_CMD_W + DATA_W;
    localparam int c_SHIFT_W = (c_CMD_W > DATA_W) ? c_CMD_W : DATA_W;
    localparam int c_CNT_W   = $clog2(c_FRAME_W + 1);
    localparam logic [c_CNT_W-1:0] c_CMD_CNT   = c_CNT_W'(c_CMD_W);
    localparam logic [c_CNT_W-1:0] c_FRAME_CNT = c_CNT_W'(c_FRAME_W);

    typedef enum logic [2:0] {
        S_WAIT_IDLE = 3'd0,
        S_IDLE      = 3'd1,
        S_CMD       = 3'd2,
        S_RD_FETCH  = 3'd3,
        S_DATA      = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    state_t r_state, w_state_next;

    logic [SYNC_STAGES-1:0] r_csn_sync, r_sclk_sync, r_mosi_sync;
    logic                   r_csn_prev, r_sclk_prev;
    logic [c_CNT_W-1:0]     r_bit_cnt;
    logic [c_SHIFT_W-2:0]   r_shift;
    logic [DATA_W-1:0]      r_tx;
    logic                   r_rnw, r_extra, r_miso;
    logic [ADDR_W-1:0]      r_reg_addr;
    logic [DATA_W-1:0]      r_reg_wdata;
    logic                   r_reg_wr, r_reg_rd, r_frame_err;

    logic                   w_csn, w_sclk, w_mosi;
    logic                   w_csn_fall, w_csn_rise, w_sclk_rise, w_sclk_fall;
    logic [c_CNT_W-1:0]     w_cnt_inc;
    logic [c_SHIFT_W-1:0]   w_shift_next;
    logic w_start, w_shift, w_decode, w_issue_rd, w_load_tx, w_tx_step;
    logic w_commit, w_err, w_extra;

    // Synchronizers reset CSN to "asserted" so WAIT_IDLE must see a genuine high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_csn_sync  <= '0;
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_csn_prev  <= 1'b0;
            r_sclk_prev <= 1'b0;
        end else begin
            r_csn_sync  <= {r_csn_sync[SYNC_STAGES-2:0], SPI_CSN};
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SPI_CLK};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], SPI_MOSI};
            r_csn_prev  <= w_csn;
            r_sclk_prev <= w_sclk;
        end
    end

    assign w_csn        = r_csn_sync[SYNC_STAGES-1];
    assign w_sclk       = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi       = r_mosi_sync[SYNC_STAGES-1];
    assign w_csn_fall   = r_csn_prev & ~w_csn;
    assign w_csn_rise   = ~r_csn_prev & w_csn;
    assign w_sclk_rise  = ~r_sclk_prev & w_sclk & ~w_csn_rise;
    assign w_sclk_fall  = r_sclk_prev & ~w_sclk & ~w_csn_rise;
    assign w_cnt_inc    = r_bit_cnt + 1'b1;
    assign w_shift_next = {r_shift, w_mosi};

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_WAIT_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_shift      = 1'b0;
        w_decode     = 1'b0;
        w_issue_rd   = 1'b0;
        w_load_tx    = 1'b0;
        w_tx_step    = 1'b0;
        w_commit     = 1'b0;
        w_err        = 1'b0;
        w_extra      = 1'b0;
        case (r_state)
            S_WAIT_IDLE: if (w_csn) w_state_next = S_IDLE;
            S_IDLE: begin
                if (w_csn_fall) begin
                    w_state_next = S_CMD;
                    w_start      = 1'b1;
                end
            end
            S_CMD: begin
                if (w_csn_rise) begin
                    w_state_next = S_IDLE;
                    w_err        = 1'b1;
                end else if (w_sclk_rise) begin
                    w_shift = 1'b1;
                    if (w_cnt_inc == c_CMD_CNT) begin
                        w_decode = 1'b1;
                        if (w_shift_next[ADDR_W]) begin
                            w_issue_rd   = 1'b1;
                            w_state_next = S_RD_FETCH;
                        end else begin
                            w_state_next = S_DATA;
                        end
                    end
                end
            end
            // First cycle has reg_rd high; the bus answers in the cycle after.
            S_RD_FETCH: begin
                if (w_csn_rise) begin
                    w_state_next = S_IDLE;
                    w_err        = 1'b1;
                end else if (!r_reg_rd) begin
                    w_load_tx    = 1'b1;
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_csn_rise) begin
                    w_state_next = S_IDLE;
                    w_err        = 1'b1;
                end else if (w_sclk_rise) begin
                    w_shift = 1'b1;
                    if (w_cnt_inc == c_FRAME_CNT) begin
                        w_commit     = ~r_rnw;
                        w_state_next = S_DONE;
                    end
                end else if (w_sclk_fall && r_rnw) begin
                    w_tx_step = 1'b1;
                end
            end
            S_DONE: begin
                if (w_csn_rise) begin
                    w_state_next = S_IDLE;
                    w_err        = r_extra;
                end else if (w_sclk_rise) begin
                    w_extra = 1'b1;
                end
            end
            default: w_state_next = S_WAIT_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_tx        <= '0;
            r_rnw       <= 1'b0;
            r_extra     <= 1'b0;
            r_miso      <= 1'b0;
            r_reg_addr  <= '0;
            r_reg_wdata <= '0;
            r_reg_wr    <= 1'b0;
            r_reg_rd    <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_reg_wr    <= w_commit;
            r_reg_rd    <= w_issue_rd;
            r_frame_err <= w_err;
            if (w_start) begin
                r_bit_cnt <= '0;
                r_shift   <= '0;
                r_extra   <= 1'b0;
            end else if (w_shift) begin
                r_bit_cnt <= w_cnt_inc;
                r_shift   <= w_shift_next[c_SHIFT_W-2:0];
            end
            if (w_extra) r_extra <= 1'b1;
            if (w_decode) begin
                r_reg_addr <= w_shift_next[ADDR_W-1:0];
                r_rnw      <= w_shift_next[ADDR_W];
            end
            if (w_commit) r_reg_wdata <= w_shift_next[DATA_W-1:0];
            if (w_load_tx)      r_tx <= reg_rdata;
            else if (w_tx_step) r_tx <= {r_tx[DATA_W-2:0], 1'b0};
            // MISO only ever carries data while a read is in its data phase.
            if (w_state_next != S_DATA) r_miso <= 1'b0;
            else if (w_tx_step)         r_miso <= r_tx[DATA_W-1];
        end
    end

    assign SPI_MISO  = r_miso;
    assign reg_addr  = r_reg_addr;
    assign reg_wr    = r_reg_wr;
    assign reg_wdata = r_reg_wdata;
    assign reg_rd    = r_reg_rd;
    assign frame_err = r_frame_err;

endmodule

`default_nettype wire

// File: tb/tb_spi_reg_responder.sv
// ============================================================================
// Module   : tb_spi_reg_responder
// Brief    : Directed self-checking bench for spi_reg_responder (SCLK half 8 clk).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_reg_responder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       SPI_CSN = 1'b1;
    logic       SPI_CLK = 1'b0;
    logic       SPI_MOSI = 1'b0;
    logic       SPI_MISO;
    logic [6:0] reg_addr;
    logic       reg_wr;
    logic [7:0] reg_wdata;
    logic       reg_rd;
    logic [7:0] reg_rdata;
    logic       frame_err;

    int tests = 0;
    int fails = 0;

    logic [31:0] miso_cap = '0;
    logic [7:0]  tb_rdata = 8'h00;
    logic        rd_d = 1'b0;

    int         wr_cnt = 0;
    int         rd_cnt = 0;
    int         err_cnt = 0;
    logic [6:0] wr_addr_l = '0;
    logic [7:0] wr_data_l = '0;
    logic [6:0] rd_addr_l = '0;

    spi_reg_responder #(.ADDR_W(7), .DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .SPI_CSN   (SPI_CSN),
        .SPI_CLK   (SPI_CLK),
        .SPI_MOSI  (SPI_MOSI),
        .SPI_MISO  (SPI_MISO),
        .reg_addr  (reg_addr),
        .reg_wr    (reg_wr),
        .reg_wdata (reg_wdata),
        .reg_rd    (reg_rd),
        .reg_rdata (reg_rdata),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // Register bus returns data only in the cycle following reg_rd.
    always @(posedge clk) rd_d <= reg_rd;
    assign reg_rdata = rd_d ? tb_rdata : 8'hEE;

    always @(negedge clk) begin
        if (reg_wr) begin
            wr_cnt    <= wr_cnt + 1;
            wr_addr_l <= reg_addr;
            wr_data_l <= reg_wdata;
        end
        if (reg_rd) begin
            rd_cnt    <= rd_cnt + 1;
            rd_addr_l <= reg_addr;
        end
        if (frame_err) err_cnt <= err_cnt + 1;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_start();
        SPI_CSN  = 1'b0;
        miso_cap = '0;
        wait_clk(8);
    endtask

    task automatic spi_bit(input logic b);
        SPI_MOSI = b;
        wait_clk(8);
        SPI_CLK  = 1'b1;
        miso_cap = {miso_cap[30:0], SPI_MISO};
        wait_clk(8);
        SPI_CLK  = 1'b0;
    endtask

    task automatic spi_bits(input logic [15:0] w, input int first, input int last);
        for (int i = first; i <= last; i++)
            spi_bit((i < 16) ? w[15-i] : 1'b0);
    endtask

    task automatic spi_end(input int gap);
        wait_clk(8);
        SPI_CSN = 1'b1;
        wait_clk(gap);
    endtask

    task automatic frame(input logic [15:0] w, input int n);
        spi_start();
        spi_bits(w, 0, n - 1);
        spi_end(12);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wait_clk(4);
        tests++;
        if ({SPI_MISO, reg_addr, reg_wr, reg_wdata, reg_rd, frame_err} !== 19'h0) begin
            fails++;
            $display("FAIL reset_in: outputs got %h expected 0",
                     {SPI_MISO, reg_addr, reg_wr, reg_wdata, reg_rd, frame_err});
        end
        rst = 1'b0;
        wait_clk(8);
        tests++;
        if ({SPI_MISO, reg_addr, reg_wr, reg_wdata, reg_rd, frame_err} !== 19'h0) begin
            fails++;
            $display("FAIL reset_out: outputs got %h expected 0",
                     {SPI_MISO, reg_addr, reg_wr, reg_wdata, reg_rd, frame_err});
        end
    endtask

    task automatic test_write();
        int w0 = wr_cnt, r0 = rd_cnt, e0 = err_cnt;
        frame(16'h05A5, 16);
        tests++; if (wr_cnt - w0 !== 1) begin fails++; $display("FAIL write_count: got %0d expected 1", wr_cnt - w0); end
        tests++; if (wr_addr_l !== 7'h05) begin fails++; $display("FAIL write_addr: got %h expected 05", wr_addr_l); end
        tests++; if (wr_data_l !== 8'hA5) begin fails++; $display("FAIL write_data: got %h expected a5", wr_data_l); end
        tests++; if (rd_cnt - r0 !== 0) begin fails++; $display("FAIL write_no_rd: got %0d expected 0", rd_cnt - r0); end
        tests++; if (err_cnt - e0 !== 0) begin fails++; $display("FAIL write_no_err: got %0d expected 0", err_cnt - e0); end
        tests++; if (miso_cap[15:0] !== 16'h0) begin fails++; $display("FAIL write_miso: got %h expected 0", miso_cap[15:0]); end
    endtask

    task automatic test_read();
        int w0 = wr_cnt, r0 = rd_cnt, e0 = err_cnt;
        tb_rdata = 8'h3C;
        frame(16'h8300, 16);
        tests++; if (rd_cnt - r0 !== 1) begin fails++; $display("FAIL read_count: got %0d expected 1", rd_cnt - r0); end
        tests++; if (rd_addr_l !== 7'h03) begin fails++; $display("FAIL read_addr: got %h expected 03", rd_addr_l); end
        tests++; if (miso_cap[7:0] !== 8'h3C) begin fails++; $display("FAIL read_miso_data: got %h expected 3c", miso_cap[7:0]); end
        tests++; if (miso_cap[15:8] !== 8'h00) begin fails++; $display("FAIL read_miso_cmd: got %h expected 00", miso_cap[15:8]); end
        tests++; if (wr_cnt - w0 !== 0) begin fails++; $display("FAIL read_no_wr: got %0d expected 0", wr_cnt - w0); end
        tests++; if (err_cnt - e0 !== 0) begin fails++; $display("FAIL read_no_err: got %0d expected 0", err_cnt - e0); end
    endtask

    task automatic test_abort();
        int w0 = wr_cnt, e0 = err_cnt;
        frame(16'h12AB, 11);
        tests++; if (wr_cnt - w0 !== 0) begin fails++; $display("FAIL abort_no_wr: got %0d expected 0", wr_cnt - w0); end
        tests++; if (err_cnt - e0 !== 1) begin fails++; $display("FAIL abort_err: got %0d expected 1", err_cnt - e0); end
        w0 = wr_cnt;
        e0 = err_cnt;
        frame(16'h12FF, 16);
        tests++; if (wr_cnt - w0 !== 1) begin fails++; $display("FAIL abort_next_count: got %0d expected 1", wr_cnt - w0); end
        tests++; if ({wr_addr_l, wr_data_l} !== 15'h12FF) begin fails++; $display("FAIL abort_next_wr: got %h expected 12ff", {wr_addr_l, wr_data_l}); end
        tests++; if (err_cnt - e0 !== 0) begin fails++; $display("FAIL abort_next_err: got %0d expected 0", err_cnt - e0); end
    endtask

    task automatic test_overlong();
        int w0 = wr_cnt, e0 = err_cnt;
        spi_start();
        spi_bits(16'h7F01, 0, 15);
        tests++; if (wr_cnt - w0 !== 1) begin fails++; $display("FAIL long_wr_at16: got %0d expected 1", wr_cnt - w0); end
        spi_bits(16'h7F01, 16, 19);
        spi_end(12);
        tests++; if (wr_cnt - w0 !== 1) begin fails++; $display("FAIL long_wr_total: got %0d expected 1", wr_cnt - w0); end
        tests++; if ({wr_addr_l, wr_data_l} !== 15'h7F01) begin fails++; $display("FAIL long_wr: got %h expected 7f01", {wr_addr_l, wr_data_l}); end
        tests++; if (miso_cap[3:0] !== 4'h0) begin fails++; $display("FAIL long_miso: got %h expected 0", miso_cap[3:0]); end
        tests++; if (err_cnt - e0 !== 1) begin fails++; $display("FAIL long_err: got %0d expected 1", err_cnt - e0); end
    endtask

    task automatic test_reset_midframe();
        int w0 = wr_cnt, r0 = rd_cnt, e0 = err_cnt;
        spi_start();
        spi_bits(16'h8B77, 0, 5);
        rst = 1'b1;
        wait_clk(1);
        tests++;
        if ({SPI_MISO, reg_addr, reg_wr, reg_wdata, reg_rd, frame_err} !== 19'h0) begin
            fails++;
            $display("FAIL mid_rst_out: got %h expected 0",
                     {SPI_MISO, reg_addr, reg_wr, reg_wdata, reg_rd, frame_err});
        end
        wait_clk(1);
        rst = 1'b0;
        spi_bits(16'h8B77, 6, 15);
        spi_end(12);
        tests++; if ((wr_cnt - w0) + (rd_cnt - r0) !== 0) begin fails++; $display("FAIL mid_no_access: got %0d expected 0", (wr_cnt - w0) + (rd_cnt - r0)); end
        tests++; if (err_cnt - e0 !== 0) begin fails++; $display("FAIL mid_no_err: got %0d expected 0", err_cnt - e0); end
        tests++;
        if ({SPI_MISO, reg_addr, reg_wr, reg_wdata, reg_rd, frame_err} !== 19'h0) begin
            fails++;
            $display("FAIL mid_outputs: got %h expected 0",
                     {SPI_MISO, reg_addr, reg_wr, reg_wdata, reg_rd, frame_err});
        end
        w0 = wr_cnt;
        frame(16'h0966, 16);
        tests++; if (wr_cnt - w0 !== 1) begin fails++; $display("FAIL mid_next_count: got %0d expected 1", wr_cnt - w0); end
        tests++; if ({wr_addr_l, wr_data_l} !== 15'h0966) begin fails++; $display("FAIL mid_next_wr: got %h expected 0966", {wr_addr_l, wr_data_l}); end
    endtask

    task automatic test_back_to_back();
        int w0 = wr_cnt, r0 = rd_cnt;
        logic [7:0] cap1;
        logic       gap_miso = 1'b0;
        tb_rdata = 8'h5A;
        spi_start();
        spi_bits(16'h8100, 0, 15);
        cap1 = miso_cap[7:0];
        wait_clk(8);
        SPI_CSN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_clk(1);
            gap_miso = gap_miso | SPI_MISO;
        end
        tb_rdata = 8'hC3;
        spi_start();
        spi_bits(16'h8200, 0, 15);
        spi_end(12);
        tests++; if (rd_cnt - r0 !== 2) begin fails++; $display("FAIL b2b_rd_count: got %0d expected 2", rd_cnt - r0); end
        tests++; if (cap1 !== 8'h5A) begin fails++; $display("FAIL b2b_miso1: got %h expected 5a", cap1); end
        tests++; if (miso_cap[7:0] !== 8'hC3) begin fails++; $display("FAIL b2b_miso2: got %h expected c3", miso_cap[7:0]); end
        tests++; if (rd_addr_l !== 7'h02) begin fails++; $display("FAIL b2b_addr2: got %h expected 02", rd_addr_l); end
        tests++; if (gap_miso !== 1'b0) begin fails++; $display("FAIL b2b_gap_miso: got %b expected 0", gap_miso); end
        tests++; if (wr_cnt - w0 !== 0) begin fails++; $display("FAIL b2b_no_wr: got %0d expected 0", wr_cnt - w0); end
    endtask

    initial begin
        wait_clk(1);
        test_reset();
        test_write();
        test_read();
        test_abort();
        test_overlong();
        test_reset_midframe();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/spi_reg_responder.md
Name: spi_reg_responder

Overview:
SPI mode-0 responder (slave) in fabric; it answers a Zynq PS SPI master (or one chip-select leg of the board SPI mux) and bridges each frame onto a simple synchronous register bus. The SPI pins are oversampled on the system clock, with no SPI_CLK clock domain. Each frame is one command word (R/nW + address) followed by one data word, MSB first.

Parameters:
ADDR_W, 7, address bits in command word; command word = 1 + ADDR_W bits
DATA_W, 8, data word width; frame length = 1 + ADDR_W + DATA_W bits
SYNC_STAGES, 2, flip-flop synchronizer depth on SPI_CSN/SPI_CLK/SPI_MOSI (min 2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
SPI_CSN  in  1  chip select, active low
SPI_CLK  in  1  SPI clock, mode 0 (idle low, sample rising, shift falling)
SPI_MOSI  in  1  master-out data
SPI_MISO  out  1  slave-out data
reg_addr  out  ADDR_W  register address, held from command decode until next frame
reg_wr  out  1  one-cycle write strobe
reg_wdata  out  DATA_W  write data, valid with reg_wr
reg_rd  out  1  one-cycle read strobe
reg_rdata  in  DATA_W  read data, sampled exactly 1 clk after reg_rd
frame_err  out  1  one-cycle pulse: frame ended with bit count not equal to frame length

Behaviour:
- Reset values: SPI_MISO=0, reg_addr=0, reg_wr=0, reg_wdata=0, reg_rd=0, frame_err=0. FSM goes to WAIT_IDLE. Bit counter=0.
- All three SPI inputs pass through SYNC_STAGES flip-flops. Edges are detected on the synchronized SPI_CLK (prev vs. current). A CSN fall or rise is detected on the synchronized SPI_CSN.
- Timing constraint: SPI_CLK high and low phases each >= SYNC_STAGES+3 clk cycles. Shorter phases are unsupported.
- FSM states:
  - WAIT_IDLE: wait for synchronized CSN=1, then go to IDLE. Exists so that a reset released mid-frame never decodes a partial frame.
  - IDLE: on CSN fall, go to CMD. Clear bit counter and shift register.
  - CMD: shift MOSI in on each rising edge. After bit 1+ADDR_W, latch reg_addr=shift[ADDR_W-1:0] and take R/nW=first bit.
    - Read: pulse reg_rd and go to RD_FETCH.
    - Write: go to DATA.
  - RD_FETCH: 1 clk later, load reg_rdata into the tx shift register, then go to DATA. This load completes before the next falling edge.
  - DATA:
    - Read: on each falling edge, present the next tx bit MSB first. The first data bit appears at the falling edge after the last command bit. Rising edges are still counted.
    - Write: shift MOSI in on rising edges.
    - After bit 1+ADDR_W+DATA_W:
      - Write: pulse reg_wr with reg_wdata=received word, 1 clk after that rising edge is detected.
      - Then go to DONE.
  - DONE: ignore further SPI_CLK edges. SPI_MISO=0. No second access. On CSN rise, go to IDLE.
- CSN rise in any state other than IDLE/WAIT_IDLE/DONE: abort and go to IDLE. No reg_wr. Pulse frame_err. A reg_rd already issued is not retracted.
- Extra clocks beyond frame length (in DONE): frame_err pulses on the CSN rise. Any write already performed stands.
- SPI_MISO is 0 whenever CSN is high, in CMD, and in DONE. SPI_MISO is never tri-stated; the upstream mux selects legs.
- CSN fall while CSN is already low cannot occur. A CSN rise and an SPI_CLK edge in the same clk: CSN wins, and the edge is discarded.
- rst in mid-frame: outputs return to reset values immediately. The remaining frame is ignored via WAIT_IDLE.

Test Plan:
- Write: ADDR_W=7, DATA_W=8, frame 0x05A5 (R/nW=0, addr 0x05, data 0xA5), SCLK half-period 8 clk -> exactly one reg_wr, reg_addr=0x05, reg_wdata=0xA5; reg_rd never asserted; frame_err=0.
- Read: frame 0x8300 with reg_rdata=0x3C supplied 1 clk after reg_rd -> reg_rd one pulse with reg_addr=0x03; master samples MISO bits 8..15 = 0x3C; no reg_wr.
- Abort: CSN raised after 11 bits of a write to 0x12 -> no reg_wr; frame_err one pulse; the following valid frame 0x12FF writes 0xFF to 0x12.
- Overlong: 20 clocks on write frame 0x7F01 -> single reg_wr (addr 0x7F, data 0x01) after bit 16; MISO=0 for bits 17-20; frame_err pulses at CSN rise.
- Reset mid-frame: assert rst for 2 clk after bit 6, release with CSN still low, complete clocks -> no reg_wr/reg_rd, all outputs 0; next frame after CSN toggle decodes normally.
- Back-to-back: two read frames (addr 0x01 then 0x02) with CSN high for 4 clk between -> two reg_rd pulses, MISO returns the respective rdata; MISO=0 while CSN high.
